// File: rtl/bus_arbiter_if.sv
// AXI4-Lite channel bundle shared by the bus arbiter, its requesters and the
// system bus. master drives requests (AW/W/AR valid+payload, B/R ready);
// slave drives the ready/response side.
interface axi4lite #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one AXI4-Lite system bus between ifetch (read-only) and the LSU.
// Reads are serialised (one outstanding), LSU writes take priority over reads
// and are never overlapped with a read.
// Build option: define ARB_ROUND_ROBIN_EN for alternating read arbitration
// instead of fixed LSU priority with an ifetch starvation guard.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  axi4lite.slave  ifetch_bus,
  axi4lite.slave  lsu_bus,
  axi4lite.master sys_bus,
  output logic   grant_ifetch,
  output logic   grant_lsu
);
  typedef enum logic [1:0] {IDLE, RADDR, RDATA, WRITE} state_t;

  state_t state, state_nx;
  logic   own_lsu, own_lsu_nx;   // current transaction owner (1 = LSU)
  logic   aw_done, aw_done_nx;
  logic   w_done, w_done_nx;
  logic   if_req, lsu_req, pick_lsu, rd_grant, b_open;

  assign if_req   = ifetch_bus.arvalid;
  assign lsu_req  = lsu_bus.arvalid;
  // a read grant is made in IDLE only when no write is pending
  assign rd_grant = (state == IDLE) && !lsu_bus.awvalid && (if_req || lsu_req);
  assign b_open   = (state == WRITE) && aw_done && w_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_if;  // last read grant went to ifetch; resets so LSU wins first
  assign pick_lsu = lsu_req && (!if_req || last_if);

  // remember the last read winner so a contested read alternates
  always_ff @(posedge clk or negedge rst)
    if (!rst)          last_if <= 1'b1;
    else if (rd_grant) last_if <= !pick_lsu;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;  // consecutive LSU read wins over a waiting ifetch
  assign pick_lsu = lsu_req && (!if_req || (starve_cnt != LIMIT));

  // count LSU wins against a waiting ifetch; saturate, clear otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve_cnt <= '0;
    else if (rd_grant) begin
      if (!pick_lsu || !if_req)  starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
`endif

  // state, owner and write-completion flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      own_lsu <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      own_lsu <= own_lsu_nx;
      aw_done <= aw_done_nx;
      w_done  <= w_done_nx;
    end

  // next state: registered arbitration in IDLE, handshake-driven elsewhere
  always_comb begin
    state_nx   = state;
    own_lsu_nx = own_lsu;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    case (state)
      IDLE: begin
        if (lsu_bus.awvalid) begin
          state_nx   = WRITE;
          own_lsu_nx = 1'b1;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end else if (rd_grant) begin
          state_nx   = RADDR;
          own_lsu_nx = pick_lsu;
        end
      end
      RADDR: if (sys_bus.arvalid && sys_bus.arready) state_nx = RDATA;
      RDATA: if (sys_bus.rvalid && sys_bus.rready)   state_nx = IDLE;
      WRITE: begin
        if (sys_bus.awvalid && sys_bus.awready) aw_done_nx = 1'b1;
        if (sys_bus.wvalid && sys_bus.wready)   w_done_nx  = 1'b1;
        if (sys_bus.bvalid && sys_bus.bready)   state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign grant_lsu    = (state != IDLE) && own_lsu;
  assign grant_ifetch = ((state == RADDR) || (state == RDATA)) && !own_lsu;

  // channel routing; every valid/ready is qualified by state so reset clears all
  always_comb begin
    // AR: mux the granted client onto the bus
    sys_bus.arvalid    = (state == RADDR) && (own_lsu ? lsu_bus.arvalid : ifetch_bus.arvalid);
    sys_bus.araddr     = own_lsu ? lsu_bus.araddr : ifetch_bus.araddr;
    sys_bus.arprot     = own_lsu ? lsu_bus.arprot : ifetch_bus.arprot;
    lsu_bus.arready    = (state == RADDR) && own_lsu && sys_bus.arready;
    ifetch_bus.arready = (state == RADDR) && !own_lsu && sys_bus.arready;
    // R: payload broadcast, valid only to the owner
    sys_bus.rready     = (state == RDATA) && (own_lsu ? lsu_bus.rready : ifetch_bus.rready);
    lsu_bus.rvalid     = (state == RDATA) && own_lsu && sys_bus.rvalid;
    ifetch_bus.rvalid  = (state == RDATA) && !own_lsu && sys_bus.rvalid;
    lsu_bus.rdata      = sys_bus.rdata;
    lsu_bus.rresp      = sys_bus.rresp;
    ifetch_bus.rdata   = sys_bus.rdata;
    ifetch_bus.rresp   = sys_bus.rresp;
    // AW/W: LSU only, each channel closes once its handshake is seen
    sys_bus.awvalid    = (state == WRITE) && !aw_done && lsu_bus.awvalid;
    sys_bus.awaddr     = lsu_bus.awaddr;
    sys_bus.awprot     = lsu_bus.awprot;
    lsu_bus.awready    = (state == WRITE) && !aw_done && sys_bus.awready;
    sys_bus.wvalid     = (state == WRITE) && !w_done && lsu_bus.wvalid;
    sys_bus.wdata      = lsu_bus.wdata;
    sys_bus.wstrb      = lsu_bus.wstrb;
    lsu_bus.wready     = (state == WRITE) && !w_done && sys_bus.wready;
    // B: opened only after both AW and W have completed
    lsu_bus.bvalid     = b_open && sys_bus.bvalid;
    lsu_bus.bresp      = sys_bus.bresp;
    sys_bus.bready     = b_open && lsu_bus.bready;
    // ifetch never writes
    ifetch_bus.awready = 1'b0;
    ifetch_bus.wready  = 1'b0;
    ifetch_bus.bvalid  = 1'b0;
    ifetch_bus.bresp   = 2'b00;
  end

  // ifetch write-side inputs are intentionally ignored
  logic unused_if_wr;
  assign unused_if_wr = ^{ifetch_bus.awvalid, ifetch_bus.awaddr, ifetch_bus.awprot,
                          ifetch_bus.wvalid, ifetch_bus.wdata, ifetch_bus.wstrb,
                          ifetch_bus.bready};
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single reads, contested read order,
// write-before-read ordering, error passthrough and mid-read reset.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic grant_ifetch, grant_lsu;
  int   n_cmp = 0;
  int   n_err = 0;

  axi4lite ifb ();
  axi4lite lsb ();
  axi4lite sysb ();

  bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifetch_bus  (ifb),
    .lsu_bus     (lsb),
    .sys_bus     (sysb),
    .grant_ifetch(grant_ifetch),
    .grant_lsu   (grant_lsu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // request a read in IDLE; grant must not appear in the same cycle
  task automatic rd_req(input bit lsu, input logic [31:0] addr);
    @(negedge clk);
    if (lsu) begin lsb.arvalid = 1'b1; lsb.araddr = addr; end
    else     begin ifb.arvalid = 1'b1; ifb.araddr = addr; end
    #1;
    chk("req_nogrant", {30'd0, grant_ifetch, grant_lsu}, 32'd0);
  endtask

  // address phase, starting in the first RADDR cycle; ar_wait stall cycles
  task automatic rd_addr(input bit lsu, input logic [31:0] addr, input int ar_wait);
    @(negedge clk); #1;
    chk("ar_grant", {30'd0, grant_ifetch, grant_lsu}, lsu ? 32'd1 : 32'd2);
    chk("ar_valid", 32'(sysb.arvalid), 32'd1);
    chk("ar_addr", sysb.araddr, addr);
    chk("ar_stall", 32'(lsu ? lsb.arready : ifb.arready), 32'd0);
    repeat (ar_wait - 1) begin
      @(negedge clk); #1;
      chk("ar_stall", 32'(lsu ? lsb.arready : ifb.arready), 32'd0);
    end
    @(negedge clk);
    sysb.arready = 1'b1;
    #1;
    chk("ar_ready", 32'(lsu ? lsb.arready : ifb.arready), 32'd1);
    chk("ar_other", 32'(lsu ? ifb.arready : lsb.arready), 32'd0);
  endtask

  // data phase in RDATA, then confirm the grant drops
  task automatic rd_data(input bit lsu, input logic [31:0] data, input logic [1:0] resp);
    @(negedge clk);
    if (lsu) lsb.arvalid = 1'b0; else ifb.arvalid = 1'b0;
    sysb.arready = 1'b0;
    sysb.rvalid = 1'b1; sysb.rdata = data; sysb.rresp = resp;
    ifb.rready = 1'b1; lsb.rready = 1'b1;
    #1;
    chk("r_valid", 32'(lsu ? lsb.rvalid : ifb.rvalid), 32'd1);
    chk("r_other", 32'(lsu ? ifb.rvalid : lsb.rvalid), 32'd0);
    chk("r_data", lsu ? lsb.rdata : ifb.rdata, data);
    chk("r_resp", 32'(lsu ? lsb.rresp : ifb.rresp), 32'(resp));
    chk("r_ready", 32'(sysb.rready), 32'd1);
    @(negedge clk);
    sysb.rvalid = 1'b0;
    #1;
    chk("r_release", {30'd0, grant_ifetch, grant_lsu}, 32'd0);
  endtask

  task automatic rd_xact(input bit lsu, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int ar_wait);
    rd_req(lsu, addr);
    rd_addr(lsu, addr, ar_wait);
    rd_data(lsu, data, resp);
  endtask

  initial begin
    int  n;
    bit  exp_l;
    {ifb.awvalid, ifb.awaddr, ifb.awprot, ifb.wvalid, ifb.wdata, ifb.wstrb, ifb.bready,
     ifb.arvalid, ifb.araddr, ifb.arprot, ifb.rready} = '0;
    {lsb.awvalid, lsb.awaddr, lsb.awprot, lsb.wvalid, lsb.wdata, lsb.wstrb, lsb.bready,
     lsb.arvalid, lsb.araddr, lsb.arprot, lsb.rready} = '0;
    {sysb.awready, sysb.wready, sysb.bvalid, sysb.bresp,
     sysb.arready, sysb.rvalid, sysb.rdata, sysb.rresp} = '0;

    // reset: requests and bus responses present, every valid/ready held low
    lsb.arvalid = 1'b1; lsb.awvalid = 1'b1; lsb.wvalid = 1'b1;
    sysb.rvalid = 1'b1; sysb.bvalid = 1'b1; sysb.arready = 1'b1;
    #1;
    chk("rst_grants", {30'd0, grant_ifetch, grant_lsu}, 32'd0);
    chk("rst_sys_valid", {29'd0, sysb.arvalid, sysb.awvalid, sysb.wvalid}, 32'd0);
    chk("rst_sys_ready", {30'd0, sysb.rready, sysb.bready}, 32'd0);
    chk("rst_cli", {27'd0, lsb.arready, lsb.rvalid, lsb.bvalid, ifb.arready, ifb.rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    lsb.arvalid = 1'b0; lsb.awvalid = 1'b0; lsb.wvalid = 1'b0;
    sysb.rvalid = 1'b0; sysb.bvalid = 1'b0; sysb.arready = 1'b0;
    rst = 1'b1;

    // ifetch alone, two stall cycles on AR
    rd_xact(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 2);

    // contested reads against a zero-wait slave
    @(negedge clk);
    ifb.arvalid = 1'b1; ifb.araddr = 32'h100;
    lsb.arvalid = 1'b1; lsb.araddr = 32'h200;
    sysb.arready = 1'b1; sysb.rvalid = 1'b1; sysb.rdata = 32'h0;
    ifb.rready = 1'b1; lsb.rready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk); #1;
      if (sysb.arvalid && sysb.arready) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_l = (n % 2) == 0;
`else
        exp_l = (n % 5) != 4;
`endif
        chk("ord_grant", {30'd0, grant_ifetch, grant_lsu}, exp_l ? 32'd1 : 32'd2);
        chk("ord_addr", sysb.araddr, exp_l ? 32'h200 : 32'h100);
        n++;
      end
    end
    chk("ord_count", n, 10);
    @(negedge clk);
    ifb.arvalid = 1'b0; lsb.arvalid = 1'b0; sysb.arready = 1'b0;
    @(negedge clk);
    sysb.rvalid = 1'b0;
    #1;
    chk("ord_release", {30'd0, grant_ifetch, grant_lsu}, 32'd0);

    // LSU write with W ahead of AW while ifetch waits to read
    @(negedge clk);
    ifb.arvalid = 1'b1; ifb.araddr = 32'h3000;
    lsb.awvalid = 1'b1; lsb.awaddr = 32'h2000;
    lsb.wvalid = 1'b1; lsb.wdata = 32'h1234_5678; lsb.wstrb = 4'hF; lsb.bready = 1'b1;
    sysb.wready = 1'b1; sysb.awready = 1'b0;
    #1;
    chk("wr_idle", {30'd0, grant_lsu, sysb.awvalid}, 32'd0);
    @(negedge clk); #1;
    chk("wr_grant", {30'd0, grant_ifetch, grant_lsu}, 32'd1);
    chk("wr_aw", {31'd0, sysb.awvalid}, 32'd1);
    chk("wr_awaddr", sysb.awaddr, 32'h2000);
    chk("wr_w", {31'd0, sysb.wvalid}, 32'd1);
    chk("wr_wdata", sysb.wdata, 32'h1234_5678);
    chk("wr_readies", {28'd0, lsb.wready, lsb.awready, ifb.awready, ifb.wready}, 32'h8);
    chk("wr_no_ar", {30'd0, sysb.arvalid, ifb.arready}, 32'd0);
    @(negedge clk);
    lsb.wvalid = 1'b0; sysb.wready = 1'b0;
    #1;
    chk("wr_w_closed", {29'd0, sysb.wvalid, sysb.awvalid, lsb.bvalid}, 32'h2);
    @(negedge clk);
    sysb.awready = 1'b1;
    #1;
    chk("wr_awready", {31'd0, lsb.awready}, 32'd1);
    @(negedge clk);
    lsb.awvalid = 1'b0; sysb.awready = 1'b0;
    sysb.bvalid = 1'b1; sysb.bresp = 2'b00;
    #1;
    chk("wr_b", {28'd0, lsb.bvalid, sysb.bready, sysb.arvalid, grant_lsu}, 32'hD);
    @(negedge clk);
    sysb.bvalid = 1'b0;
    #1;
    chk("wr_gap", {30'd0, grant_lsu, sysb.arvalid}, 32'd0);
    rd_addr(1'b0, 32'h3000, 1);
    rd_data(1'b0, 32'h0BAD_F00D, 2'b00);

    // SLVERR passes through unchanged, then normal service resumes
    rd_xact(1'b1, 32'hFFFF_0000, 32'h0000_0000, 2'b10, 1);
    rd_xact(1'b0, 32'h0000_1004, 32'hCAFE_F00D, 2'b00, 1);

    // reset during a stalled RDATA
    rd_req(1'b0, 32'h0000_1008);
    rd_addr(1'b0, 32'h0000_1008, 1);
    @(negedge clk);
    ifb.arvalid = 1'b0; sysb.arready = 1'b0;
    sysb.rvalid = 1'b1; sysb.rdata = 32'h5555_AAAA; ifb.rready = 1'b0;
    #1;
    chk("mid_rvalid", {31'd0, ifb.rvalid}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {28'd0, ifb.rvalid, lsb.rvalid, sysb.rready, sysb.arvalid}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_ifetch, grant_lsu}, 32'd0);
    @(negedge clk);
    rst = 1'b1; sysb.rvalid = 1'b0;
    rd_xact(1'b0, 32'h0000_100C, 32'h7777_0001, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the core's single AXI4-Lite system bus between two requesters: instruction fetch (read-only) and the load/store unit (LSU, read and write).
- Sits between ifetch/LSU and the sys_bus port of core.
- Reads are serialised: one outstanding read at a time, arbitrated by fixed priority with a starvation guard.
- LSU write channels (AW/W/B) pass through, gated so no write issues while a read is in flight.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive LSU read grants while ifetch is waiting before ifetch is forced a grant; range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- ifetch_bus  axi4lite.slave  interface  ifetch requester; only AR/R used; AW/W tied not-ready, no B responses
- lsu_bus  axi4lite.slave  interface  LSU requester; all five channels
- sys_bus  axi4lite.master  interface  shared system bus
- grant_ifetch  output  1  current read owner is ifetch (debug/perf)
- grant_lsu  output  1  current read or write owner is LSU

Behaviour:
- States: IDLE, RADDR, RDATA, WRITE.
- Reset (rst low, async): state=IDLE, starve_cnt=0, grant_ifetch=0, grant_lsu=0. All valid/ready outputs on every interface are 0.
- IDLE arbitration, registered; the request is seen in cycle N and the grant is active in cycle N+1:
  - LSU awvalid has top priority: go to WRITE, grant_lsu=1.
  - Otherwise, if both arvalid: grant LSU unless starve_cnt==STARVE_LIMIT, in which case grant ifetch.
  - Otherwise grant the single requester.
  - A read grant goes to RADDR.
- starve_cnt:
  - Increments on each LSU read grant made while ifetch_bus.arvalid=1.
  - Clears on any ifetch grant, or on an LSU grant made while ifetch is idle.
  - Saturates at STARVE_LIMIT.
- RADDR:
  - sys_bus.arvalid = granted client arvalid; araddr and arprot are forwarded combinationally.
  - Client arready = sys_bus.arready; the non-granted client sees arready=0.
  - On the AR handshake, go to RDATA.
- RDATA:
  - sys_bus R channel is routed to the granted client: rvalid, rdata, rresp forwarded; sys_bus.rready = client rready.
  - Non-granted client sees rvalid=0.
  - On the R handshake, go to IDLE and drop the grant the next cycle.
- WRITE:
  - AW and W are forwarded independently; they may complete in either order or the same cycle.
  - Completion is tracked with aw_done/w_done flags.
  - Once both are done, B is forwarded. On the B handshake, go to IDLE.
- A new transaction never starts the same cycle a previous one ends; minimum one IDLE cycle between transactions.
- Requesters must hold valid/address stable until ready (AXI rule). The arbiter never drops an accepted request.
- A client deasserting arvalid before grant is legal in IDLE only.
- The arbiter does not reorder: an LSU write followed by an LSU read completes the write's B before the read's AR is issued.
- Reset asserted mid-transaction returns to IDLE immediately. The bus is assumed reset together with the arbiter.
- An rresp or bresp error is passed through unchanged; the arbiter takes no action on it.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined: STARVE_LIMIT is ignored and starve_cnt is removed. Read arbitration alternates: when both request, the client not granted last read wins. The last-grant bit resets to "ifetch last", so LSU wins first. Write priority over reads is unchanged.
- Undefined: fixed priority with starvation guard, as above.

Test Plan:
- Reset mid-RDATA (rst low for 1 cycle) -> all valids 0 within the same cycle; state IDLE; grant_* = 0; next ifetch arvalid is granted 1 cycle later.
- ifetch alone reads 0x0000_1000, sys_bus arready after 2 cycles, rdata=0xDEAD_BEEF -> sys_bus.araddr=0x1000; ifetch receives 0xDEAD_BEEF with rresp=OKAY; lsu_bus rvalid stays 0.
- Both request reads continuously, STARVE_LIMIT=4, bus zero-wait -> grant order LSU,LSU,LSU,LSU,ifetch, repeating. With ARB_ROUND_ROBIN_EN: LSU,ifetch,LSU,ifetch.
- LSU write to 0x2000 data 0x1234_5678, W handshake 2 cycles before AW, while ifetch arvalid=1 -> ifetch AR is not issued until the B handshake plus 1 IDLE cycle; sys_bus sees awaddr=0x2000, wdata=0x1234_5678.
- sys_bus returns rresp=SLVERR for an LSU read of 0xFFFF_0000 -> LSU receives SLVERR; the arbiter returns to IDLE and serves the next request normally.
